// File: rtl/bmp_stream_reader.sv
// rtl/bmp_stream_reader.sv - streams a 24-bit image from RAM as a BMP byte stream (54-byte header + pixels).
// Optional BMP_STREAM_PREFETCH_EN overlaps the next pixel read with the current pixel's bytes.
module bmp_stream_reader #(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256,
    parameter int ADDR_W = 16,
    parameter int PPM    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [23:0]       RAM_Q,
    output logic [ADDR_W-1:0] RAM_A,
    output logic              RAM_OE,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              byte_last,
    output logic              busy
);

    localparam logic [31:0]       IMG_SIZE  = 32'(3 * WIDTH * HEIGHT);
    localparam logic [31:0]       FILE_SIZE = 32'd54 + IMG_SIZE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_FETCH,
        S_WAIT,
        S_SEND
    } state_t;

    state_t            state, state_nx;
    logic [5:0]        hdr_idx;
    logic [ADDR_W-1:0] pix_addr;
    logic [1:0]        sub;
    logic [23:0]       pix_reg;
    logic [31:0]       hdr_field;
    logic [1:0]        hdr_bo;
    logic [7:0]        hdr_byte;
    logic              accept;
    logic              at_last;
    logic              pix_done;

`ifdef BMP_STREAM_PREFETCH_EN
    logic [23:0]       pf_reg;
    logic              pf_issued;
    logic              rd_pend;
    logic              pf_fetch;
`endif

    assign accept   = byte_valid && byte_ready;
    assign at_last  = (pix_addr == LAST_ADDR);
    assign pix_done = (state == S_SEND) && accept && (sub == 2'd2);

`ifdef BMP_STREAM_PREFETCH_EN
    assign pf_fetch = (state == S_SEND) && (sub == 2'd1) && !pf_issued && !at_last;
`endif

    // Every header field starts at an offset congruent to 2 mod 4, so (idx-2) picks the byte lane.
    assign hdr_bo = 2'(hdr_idx - 6'd2);

    always_comb begin
        hdr_field = 32'd0;
        if (hdr_idx < 6'd2)
            hdr_field = 32'h4D42_0000;
        else if (hdr_idx < 6'd6)
            hdr_field = FILE_SIZE;
        else if (hdr_idx < 6'd10)
            hdr_field = 32'd0;
        else if (hdr_idx < 6'd14)
            hdr_field = 32'd54;
        else if (hdr_idx < 6'd18)
            hdr_field = 32'd40;
        else if (hdr_idx < 6'd22)
            hdr_field = 32'(WIDTH);
        else if (hdr_idx < 6'd26)
            hdr_field = 32'(HEIGHT);
        else if (hdr_idx < 6'd30)
            hdr_field = {16'd24, 16'd1};
        else if (hdr_idx < 6'd34)
            hdr_field = 32'd0;
        else if (hdr_idx < 6'd38)
            hdr_field = IMG_SIZE;
        else if (hdr_idx < 6'd46)
            hdr_field = 32'(PPM);
        hdr_byte = hdr_field[{hdr_bo, 3'b000} +: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        byte_last  = 1'b0;
        RAM_OE     = 1'b0;
        RAM_A      = '0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start)
                    state_nx = S_HEADER;
            end
            S_HEADER: begin
                byte_valid = 1'b1;
                byte_data  = hdr_byte;
                if (accept && hdr_idx == 6'd53)
                    state_nx = S_FETCH;
            end
            S_FETCH: begin
                RAM_OE   = 1'b1;
                RAM_A    = pix_addr;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                state_nx = S_SEND;
            end
            S_SEND: begin
                byte_valid = 1'b1;
                case (sub)
                    2'd0:    byte_data = pix_reg[23:16];
                    2'd1:    byte_data = pix_reg[15:8];
                    default: byte_data = pix_reg[7:0];
                endcase
                byte_last = (sub == 2'd2) && at_last;
`ifdef BMP_STREAM_PREFETCH_EN
                if (pf_fetch) begin
                    RAM_OE = 1'b1;
                    RAM_A  = pix_addr + ADDR_W'(1);
                end
                if (pix_done)
                    state_nx = at_last ? S_IDLE : S_SEND;
`else
                if (pix_done)
                    state_nx = at_last ? S_IDLE : S_FETCH;
`endif
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_idx  <= 6'd0;
            pix_addr <= '0;
            sub      <= 2'd0;
            pix_reg  <= 24'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        hdr_idx  <= 6'd0;
                        pix_addr <= '0;
                    end
                end
                S_HEADER: begin
                    if (accept)
                        hdr_idx <= hdr_idx + 6'd1;
                end
                S_WAIT: begin
                    pix_reg <= RAM_Q;
                    sub     <= 2'd0;
                end
                S_SEND: begin
                    if (accept) begin
                        if (sub == 2'd2) begin
                            sub <= 2'd0;
                            if (!at_last) begin
                                pix_addr <= pix_addr + ADDR_W'(1);
`ifdef BMP_STREAM_PREFETCH_EN
                                // Read data may be landing on this very edge; bypass the prefetch register.
                                pix_reg  <= rd_pend ? RAM_Q : pf_reg;
`endif
                            end
                        end else begin
                            sub <= sub + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BMP_STREAM_PREFETCH_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pf_reg    <= 24'd0;
            pf_issued <= 1'b0;
            rd_pend   <= 1'b0;
        end else begin
            rd_pend <= pf_fetch;
            if (rd_pend)
                pf_reg <= RAM_Q;
            if (pf_fetch)
                pf_issued <= 1'b1;
            else if (pix_done || state != S_SEND)
                pf_issued <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_bmp_stream_reader.sv
// tb/tb_bmp_stream_reader.sv - self-checking bench for bmp_stream_reader against a byte-stream reference model.
module tb_bmp_stream_reader;

    localparam int W     = 8;
    localparam int H     = 4;
    localparam int AW    = 16;
    localparam int PPMV  = 2835;
    localparam int N     = W * H;
    localparam int TOTAL = 54 + 3 * N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [23:0]   ram_q;
    logic [AW-1:0] ram_a;
    logic          ram_oe;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_ready;
    logic          byte_last;
    logic          busy;

    bmp_stream_reader #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .PPM(PPMV)) dut (
        .clk(clk), .rst(rst_n), .start(start),
        .RAM_Q(ram_q), .RAM_A(ram_a), .RAM_OE(ram_oe),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_last(byte_last), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [23:0] ram [0:N-1];
    always @(posedge clk) if (ram_oe) ram_q <= ram[int'(ram_a)];

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    int         last_cnt, last_idx, stable_err, oe_cnt, first_cyc, last_cyc;
    int         last_a;
    bit         finished;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put32(input int off, input logic [31:0] v);
        for (int i = 0; i < 4; i++) exp_q[off + i] = v[8*i +: 8];
    endtask

    task automatic build_model();
        exp_q.delete();
        for (int i = 0; i < TOTAL; i++) exp_q.push_back(8'h00);
        exp_q[0] = 8'h42;
        exp_q[1] = 8'h4D;
        put32(2, TOTAL);
        put32(10, 54);
        put32(14, 40);
        put32(18, W);
        put32(22, H);
        exp_q[26] = 8'd1;
        exp_q[28] = 8'd24;
        put32(34, 3 * N);
        put32(38, PPMV);
        put32(42, PPMV);
        for (int p = 0; p < N; p++) begin
            exp_q[54 + 3*p]     = ram[p][23:16];
            exp_q[54 + 3*p + 1] = ram[p][15:8];
            exp_q[54 + 3*p + 2] = ram[p][7:0];
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ram_a"}, ram_a, 0);
        check({tag, "_ram_oe"}, ram_oe, 0);
        check({tag, "_valid"}, byte_valid, 0);
        check({tag, "_last"}, byte_last, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic compare_stream(input string tag);
        int mm = 0;
        for (int i = 0; i < TOTAL && i < got.size(); i++)
            if (got[i] !== exp_q[i]) mm++;
        check({tag, "_count"}, got.size(), TOTAL);
        check({tag, "_byte_mismatches"}, mm, 0);
        check({tag, "_last_count"}, last_cnt, 1);
        check({tag, "_last_index"}, last_idx, TOTAL - 1);
    endtask

    // Runs one dump; stops early when abort_at bytes are accepted by pulling reset.
    task automatic run_dump(input bit rnd, input bit poke, input int abort_at);
        int         cyc = 0;
        bit         stalled = 0;
        logic [7:0] held = 8'h00;
        got.delete();
        last_cnt = 0; last_idx = -1; stable_err = 0; oe_cnt = 0; last_a = -1;
        first_cyc = -1; last_cyc = -1; finished = 0;
        @(negedge clk);
        start = 1'b1;
        byte_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("first_byte_latency", byte_valid, 1);
        while (!finished && cyc < 5000) begin
            start = 1'b0;
            if (ram_oe) begin oe_cnt++; last_a = int'(ram_a); end
            if (stalled && byte_valid !== 1'b1) stable_err++;
            if (stalled && byte_data !== held) stable_err++;
            byte_ready = rnd ? ($urandom_range(0, 9) < 4) : 1'b1;
            if (byte_valid && byte_ready) begin
                got.push_back(byte_data);
                if (byte_last) begin last_cnt++; last_idx = got.size() - 1; end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (poke && got.size() == 70) start = 1'b1;
                if (byte_last) begin
                    finished = 1;
                    if (poke) start = 1'b1;
                end
                stalled = 0;
            end else begin
                stalled = byte_valid;
                held = byte_data;
            end
            if (abort_at > 0 && got.size() == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_outputs_zero("midreset");
                finished = 1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (abort_at == 0) check("dump_completed", finished, 1);
    endtask

    initial begin
        int quiet;
        rst_n = 1'b0;
        start = 1'b0;
        byte_ready = 1'b0;
        for (int i = 0; i < N; i++) ram[i] = 24'($urandom);
        ram[0] = 24'h112233;
        ram[1] = 24'h445566;
        build_model();
        #1;
        check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Full-rate dump with start pokes mid-stream and on the final accept.
        run_dump(0, 1, 0);
        compare_stream("full_rate");
        check("busy_after_last", busy, 0);
        check("hdr_B", got[0], 8'h42);
        check("hdr_M", got[1], 8'h4D);
        for (int i = 0; i < 6; i++) check("pixel_order", got[54 + i], 8'h11 * (i + 1));
        check("fetch_count", oe_cnt, N);
        check("last_fetch_addr", last_a, N - 1);
`ifdef BMP_STREAM_PREFETCH_EN
        check("throughput_span", last_cyc - first_cyc, 55 + 3 * N);
`else
        check("throughput_span", last_cyc - first_cyc, 53 + 5 * N);
`endif
        quiet = 0;
        for (int i = 0; i < 20; i++) begin
            if (byte_valid || busy) quiet++;
            @(negedge clk);
        end
        check("no_restart_after_ignored_start", quiet, 0);

        // Random backpressure must yield the same stream with stable held bytes.
        run_dump(1, 0, 0);
        compare_stream("backpressure");
        check("hold_stable", stable_err, 0);
        check("bp_fetch_count", oe_cnt, N);

        // Abort mid-stream, verify silence, then a clean restart.
        run_dump(0, 0, 100);
        check("abort_byte_count", got.size(), 100);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            if (byte_valid || busy || ram_oe) quiet++;
            @(negedge clk);
        end
        check("silent_after_reset", quiet, 0);
        run_dump(1, 0, 0);
        compare_stream("restart");
        check("restart_first_B", got[0], 8'h42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
